// File: rtl/lcg_stim_sequencer.sv
// LCG-driven stimulus sequencer: fills IN_W-bit vectors one 32-bit chunk per clock,
// presents them over valid/ready, and folds each DUT response into a rotating signature.
module lcg_stim_sequencer #(
    parameter int unsigned IN_W  = 140,
    parameter int unsigned OUT_W = 159,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] cycles,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic             stim_ready,
    input  logic [OUT_W-1:0] dut_out,
    output logic [31:0]      sig,
    output logic [CNT_W:0]   vec_count,
    output logic             busy,
    output logic             done
);
    localparam int unsigned NCHUNK = (IN_W + 31) / 32;
    localparam int unsigned OCHUNK = (OUT_W + 31) / 32;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRESENT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      rng_q, rng_d, rng_next;
    logic [IN_W-1:0]  shadow_q, shadow_d, stim_q, stim_d, chunk_ins, chunk_msk, filled;
    logic [31:0]      sig_q, sig_d, fold;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [KW-1:0]    k_q, k_d;
    logic [OCHUNK*32-1:0] out_pad;
    logic             last_chunk, last_vec;

    assign rng_next   = rng_q * 32'h41C6_4E6D + 32'h0000_3039;
    assign last_chunk = (k_q == K_LAST);
    assign last_vec   = (cnt_q == {1'b0, cycles_q});

    // Zero-extended widening drops the bits of the last chunk that fall beyond IN_W.
    assign chunk_ins = IN_W'(rng_next) << (32 * k_q);
    assign chunk_msk = IN_W'(32'hFFFF_FFFF) << (32 * k_q);
    assign filled    = (shadow_q & ~chunk_msk) | chunk_ins;

    always_comb begin
        fold    = '0;
        out_pad = (OCHUNK * 32)'(dut_out);
        for (int unsigned c = 0; c < OCHUNK; c++) begin
            fold    = fold ^ out_pad[31:0];
            out_pad = out_pad >> 32;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rng_q    <= '0;
            shadow_q <= '0;
            stim_q   <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            rng_q    <= rng_d;
            shadow_q <= shadow_d;
            stim_q   <= stim_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_FILL;
            S_FILL:         if (last_chunk) state_d = S_PRESENT;
            S_PRESENT:      if (stim_ready) state_d = last_vec ? S_DONE : S_FILL;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rng_d    = rng_q;
        shadow_d = shadow_q;
        stim_d   = stim_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        k_d      = k_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rng_d    = seed;
                    cycles_d = cycles;
                    sig_d    = '0;
                    cnt_d    = '0;
                    k_d      = '0;
                end
            end
            S_FILL: begin
                rng_d    = rng_next;
                shadow_d = filled;
                k_d      = k_q + KW'(1);
                if (last_chunk) stim_d = filled;
            end
            S_PRESENT: begin
                if (stim_ready) begin
                    sig_d = {sig_q[30:0], sig_q[31]} ^ fold;
                    cnt_d = cnt_q + (CNT_W + 1)'(1);
                    k_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stim_valid = (state_q == S_PRESENT);
        busy       = (state_q == S_FILL) || (state_q == S_PRESENT);
        done       = (state_q == S_DONE);
    end

    assign stim      = stim_q;
    assign sig       = sig_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_lcg_stim_sequencer.sv
// Randomized bench for lcg_stim_sequencer against a software-LCG reference model.
module tb_lcg_stim_sequencer;
    localparam int unsigned IN_W  = 140;
    localparam int unsigned OUT_W = 159;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned NCH   = (IN_W + 31) / 32;
    localparam int unsigned NCO   = (OUT_W + 31) / 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      seed = '0;
    logic [CNT_W-1:0] cycles = '0;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic             stim_ready = 1'b0;
    logic [OUT_W-1:0] dut_out = '0;
    logic [31:0]      sig;
    logic [CNT_W:0]   vec_count;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mx;

    always #5 clk = ~clk;

    lcg_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .cycles(cycles),
        .stim(stim), .stim_valid(stim_valid), .stim_ready(stim_ready),
        .dut_out(dut_out), .sig(sig), .vec_count(vec_count),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Software LCG: each vector consumes NCH successive values, chunk 0 first.
    task automatic next_vec(output logic [IN_W-1:0] v);
        logic [NCH*32-1:0] acc;
        acc = '0;
        for (int c = 0; c < NCH; c++) begin
            mx  = mx * 32'h41C64E6D + 32'h3039;
            acc = acc | ((NCH * 32)'(mx) << (32 * c));
        end
        v = acc[IN_W-1:0];
    endtask

    function automatic logic [31:0] fold_of(input logic [OUT_W-1:0] d);
        logic [NCO*32-1:0] w;
        logic [31:0] f;
        w = (NCO * 32)'(d);
        f = '0;
        for (int i = 0; i < NCO; i++) f = f ^ w[32*i +: 32];
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim"}, stim, 0);
        check({tag, "_valid"}, stim_valid, 0);
        check({tag, "_sig"}, sig, 0);
        check({tag, "_cnt"}, vec_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ten-cycle stall on first vector.
    // dmode: 0 random response, 1 constant one, 2 response derived from expected vector.
    task automatic do_run(input logic [31:0] sd, input int unsigned ncyc, input int rmode,
                          input int dmode, input bit noise, output logic [31:0] final_sig);
        logic [IN_W-1:0] ev;
        logic [31:0] msig;
        int edge_n, stall;
        bit ok, hs, seen;
        final_sig = '0;
        seed = sd; cycles = ncyc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; edge_n = 0; mx = sd; msig = '0;
        check("start_sig_clear", sig, 0);
        check("start_cnt_clear", vec_count, 0);
        for (int unsigned j = 0; j <= ncyc; j++) begin
            next_vec(ev);
            stall = 0; ok = 1'b0; seen = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                check("busy_in_run", busy, 1);
                check("done_in_run", done, 0);
                if (stim_valid) begin
                    check("stim", stim, ev);
                    if (!seen && rmode == 0) check("valid_edge", edge_n, 6 * j + 5);
                    seen = 1'b1;
                    case (rmode)
                        0:       stim_ready = 1'b1;
                        1:       stim_ready = 1'($urandom % 2);
                        default: begin
                            stim_ready = (j != 0) || (stall >= 10);
                            stall++;
                        end
                    endcase
                    case (dmode)
                        0:       dut_out = OUT_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
                        1:       dut_out = OUT_W'(1);
                        default: dut_out = {ev, 19'h5A5A5};
                    endcase
                end else begin
                    stim_ready = (rmode == 1) ? 1'($urandom % 2) : 1'b1;
                end
                if (noise) begin
                    start  = 1'($urandom % 2);
                    seed   = $urandom;
                    cycles = $urandom;
                end
                hs = stim_valid && stim_ready;
                @(posedge clk); #1;
                edge_n++;
                if (hs) begin
                    ok   = 1'b1;
                    msig = {msig[30:0], msig[31]} ^ fold_of(dut_out);
                    check("sig", sig, msig);
                    check("vec_count", vec_count, j + 1);
                    if (rmode == 0) check("hs_edge", edge_n, 6 * (j + 1));
                end
            end
            if (!ok) begin
                check("handshake_timeout", 0, 1);
                start = 1'b0; stim_ready = 1'b0;
                return;
            end
        end
        start = 1'b0; stim_ready = 1'b0;
        check("done_end", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", stim_valid, 0);
        final_sig = msig;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s1;
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_run(32'h0, 0, 0, 0, 1'b0, s1);
        check("seed0_chunk0", stim[31:0], 32'h00003039);
        check("seed0_chunk1", stim[63:32], 32'hD3DC167E);
        check("seed0_count", vec_count, 1);

        do_run(32'h1234, 1, 0, 1, 1'b0, s1);
        check("ones_sig", sig, 32'h3);
        check("ones_count", vec_count, 2);

        do_run(32'hCAFE, 1, 2, 0, 1'b0, s1);
        do_run(32'h0BAD, 3, 0, 0, 1'b1, s1);

        seed = 32'h777; cycles = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1; #1;
        check_reset_outputs("midfill_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        do_run(32'h777, 0, 0, 0, 1'b0, s1);

        do_run(32'h0, 2, 0, 2, 1'b0, s1);
        do_run(32'h0, 2, 0, 2, 1'b0, s1);
        check("repeat_sig", sig, s1);
        check("repeat_count", vec_count, 3);

        for (int r = 0; r < 6; r++)
            do_run($urandom, $urandom_range(0, 4), 1, 0, 1'($urandom % 2), s1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
